dmem_resp: RTL and testbench

Synthesizable, parametrised data-memory responder that replaces behavioural memory emulation in simulation and FPGA bring-up of the pipeline core. It serves the core's data-bus protocol (MREQ/WRITE/SIZE, active-low ACKD_n) with a programmable access latency, byte-addressed storage and the codebase's byte-lane mapping. It also decodes memory-mapped STDOUT and EXIT addresses, with a buffered stdout byte stream and a sticky exit flag.

---
 rtl/dmem_resp_if.sv | 21 ++
 rtl/dmem_resp.sv | 272 +++++++++++++++++++++++++++
 tb/tb_dmem_resp.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// Core data-bus bundle: request, store data and size from the core; load data
// and the active-low completion strobe from the memory responder.
interface dmem_resp_if;
    logic        mreq;
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack_n;

    modport master (
        output mreq, write, size, addr, wdata,
        input  rdata, ack_n
    );

    modport slave (
        input  mreq, write, size, addr, wdata,
        output rdata, ack_n
    );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder with programmable ack latency, byte-lane storage,
// memory-mapped stdout FIFO and a sticky exit/terminate register.
module dmem_resp #(
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0800_0000,
    parameter int          DEPTH_BYTES = 65536,
    parameter logic [31:0] STDOUT_ADDR = 32'hf000_0000,
    parameter logic [31:0] EXIT_ADDR   = 32'hff00_0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter string       INIT_FILE   = ""
) (
    input  logic        i_clk,
    input  logic        i_rst,
    dmem_resp_if.slave  bus,
    output logic        o_so_valid,
    output logic [7:0]  o_so_data,
    input  logic        i_so_ready,
    output logic        o_exit,
    output logic [31:0] o_exit_code,
    output logic        o_err
);
    localparam int IW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_write;
    logic [1:0]    r_size;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_ack_n;
    logic [31:0]   r_rdata;
    logic          r_exit;
    logic [31:0]   r_exit_code;
    logic          r_err;

    logic [7:0]    r_mem [DEPTH_BYTES];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [FW:0]   r_wp;
    logic [FW:0]   r_rp;
    logic          r_so_valid;
    logic [7:0]    r_so_data;

    logic          w_in_wait;
    logic          w_start;
    logic          w_write;
    logic [1:0]    w_size;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [31:0]   w_off;
    logic [31:0]   w_b;
    logic [2:0]    w_nb;
    logic          w_oor;
    logic          w_is_so;
    logic          w_is_exit;
    logic          w_special;
    logic [IW-1:0] w_idx;
    logic          w_fifo_full;
    logic          w_pop;
    logic          w_so_byte;
    logic          w_stall;
    logic          w_can_ack;
    logic          w_commit;
    logic          w_push;
    logic          w_mem_we;
    logic          w_err_set;
    logic [31:0]   w_load_val;
    logic [FW:0]   w_wp_n;
    logic [FW:0]   w_rp_n;
    logic [7:0]    w_head_n;

    // While waiting the latched request is authoritative; otherwise the live bus is.
    assign w_in_wait = (r_state == ST_WAIT);
    assign w_start   = ((r_state == ST_IDLE) || (r_state == ST_ACK)) && bus.mreq;
    assign w_write   = w_in_wait ? r_write : bus.write;
    assign w_size    = w_in_wait ? r_size  : bus.size;
    assign w_addr    = w_in_wait ? r_addr  : bus.addr;
    assign w_wdata   = w_in_wait ? r_wdata : bus.wdata;

    assign w_off     = w_addr - BASE_ADDR;
    assign w_is_so   = (w_addr == STDOUT_ADDR);
    assign w_is_exit = (w_addr == EXIT_ADDR);
    assign w_special = w_is_so || w_is_exit;

    // Lowest touched byte offset and access width, using the core's lane swizzle.
    always_comb begin
        w_b  = w_off;
        w_nb = 3'd4;
        case (w_size)
            2'b00: begin
                w_b  = w_off;
                w_nb = 3'd4;
            end
            2'b01: begin
                w_b  = {w_off[31:2], 2'b10} - {30'd0, w_addr[1:0]};
                w_nb = 3'd2;
            end
            default: begin
                w_b  = {w_off[31:2], 2'b11} - {30'd0, w_addr[1:0]};
                w_nb = 3'd1;
            end
        endcase
    end

    assign w_oor = (({1'b0, w_b} + {30'd0, w_nb}) > 33'(DEPTH_BYTES));
    assign w_idx = w_b[IW-1:0];

    assign w_fifo_full = (r_wp[FW] != r_rp[FW]) && (r_wp[FW-1:0] == r_rp[FW-1:0]);
    assign w_pop       = r_so_valid && i_so_ready;
    assign w_so_byte   = w_write && w_is_so && w_size[1];
    assign w_stall     = w_so_byte && w_fifo_full && !w_pop;

    assign w_can_ack = (w_start && (LATENCY == 1)) ||
                       (w_in_wait && bus.mreq && (r_cnt <= CW'(1)));
    assign w_commit  = w_can_ack && !w_stall;
    assign w_push    = w_commit && w_so_byte;
    assign w_mem_we  = w_commit && w_write && !w_special && !w_oor;
    assign w_err_set = w_commit && ((!w_special && w_oor) ||
                                    (w_write && w_is_so && !w_size[1]));

    // Load data for the access being committed; zero for stores, sinks and misses.
    always_comb begin
        w_load_val = 32'h0;
        if (!w_write && !w_special && !w_oor) begin
            case (w_size)
                2'b00:   w_load_val = {r_mem[w_idx], r_mem[w_idx + IW'(1)],
                                       r_mem[w_idx + IW'(2)], r_mem[w_idx + IW'(3)]};
                2'b01:   w_load_val = {16'h0, r_mem[w_idx], r_mem[w_idx + IW'(1)]};
                default: w_load_val = {24'h0, r_mem[w_idx]};
            endcase
        end else begin
            w_load_val = 32'h0;
        end
    end

    assign w_wp_n = w_push ? (r_wp + (FW+1)'(1)) : r_wp;
    assign w_rp_n = w_pop  ? (r_rp + (FW+1)'(1)) : r_rp;

    // Next head byte, forwarding a byte pushed into the slot that becomes the head.
    always_comb begin
        w_head_n = 8'h0;
        if (w_wp_n == w_rp_n) begin
            w_head_n = 8'h0;
        end else if (w_push && (r_wp[FW-1:0] == w_rp_n[FW-1:0])) begin
            w_head_n = w_wdata[7:0];
        end else begin
            w_head_n = r_fifo[w_rp_n[FW-1:0]];
        end
    end

    // Access FSM with registered ack, load data and sticky status.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CW'(0);
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_ack_n     <= 1'b1;
            r_rdata     <= 32'h0;
            r_exit      <= 1'b0;
            r_exit_code <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            r_ack_n <= ~w_commit;
            r_rdata <= w_commit ? w_load_val : 32'h0;
            if (w_commit && w_write && w_is_exit && !r_exit) begin
                r_exit      <= 1'b1;
                r_exit_code <= w_wdata;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_ACK: begin
                    if (bus.mreq) begin
                        r_write <= bus.write;
                        r_size  <= bus.size;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        if (w_commit) begin
                            r_state <= ST_ACK;
                            r_cnt   <= CW'(0);
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CW'(LATENCY - 1);
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CW'(0);
                    end
                end
                ST_WAIT: begin
                    if (!bus.mreq) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CW'(0);
                    end else if (w_commit) begin
                        r_state <= ST_ACK;
                        r_cnt   <= CW'(0);
                    end else if (r_cnt > CW'(1)) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_cnt <= CW'(0);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= CW'(0);
                end
            endcase
        end
    end

    // Stdout FIFO pointers and registered head view.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_so_valid <= 1'b0;
            r_so_data  <= 8'h0;
        end else begin
            r_wp       <= w_wp_n;
            r_rp       <= w_rp_n;
            r_so_valid <= (w_wp_n != w_rp_n);
            r_so_data  <= w_head_n;
        end
    end

    // Stdout FIFO storage.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_fifo[r_wp[FW-1:0]] <= w_wdata[7:0];
        end
    end

    // Byte storage; survives reset, never written while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (w_mem_we && !i_rst) begin
            case (w_size)
                2'b00: begin
                    r_mem[w_idx]          <= w_wdata[31:24];
                    r_mem[w_idx + IW'(1)] <= w_wdata[23:16];
                    r_mem[w_idx + IW'(2)] <= w_wdata[15:8];
                    r_mem[w_idx + IW'(3)] <= w_wdata[7:0];
                end
                2'b01: begin
                    r_mem[w_idx]          <= w_wdata[15:8];
                    r_mem[w_idx + IW'(1)] <= w_wdata[7:0];
                end
                default: begin
                    r_mem[w_idx] <= w_wdata[7:0];
                end
            endcase
        end
    end

    assign bus.rdata   = r_rdata;
    assign bus.ack_n   = r_ack_n;
    assign o_so_valid  = r_so_valid;
    assign o_so_data   = r_so_data;
    assign o_exit      = r_exit;
    assign o_exit_code = r_exit_code;
    assign o_err       = r_err;
endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: one instance at LATENCY=3 and one at LATENCY=1, sharing
// a request driver; expected load data flows through a scoreboard queue.
module tb_dmem_resp;
    localparam logic [31:0] BASE   = 32'h0800_0000;
    localparam int          DEPTH  = 4096;
    localparam logic [31:0] SO_A   = 32'hf000_0000;
    localparam logic [31:0] EXIT_A = 32'hff00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tb_sel = 1'b0;
    logic        tb_mreq = 1'b0;
    logic        tb_write = 1'b0;
    logic [1:0]  tb_size = 2'b00;
    logic [31:0] tb_addr = 32'h0;
    logic [31:0] tb_wdata = 32'h0;
    logic        so_ready_b = 1'b0;

    logic        so_valid_a, so_valid_b, exit_a, exit_b, err_a, err_b;
    logic [7:0]  so_data_a, so_data_b;
    logic [31:0] exit_code_a, exit_code_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb_q[$];
    logic [7:0]  so_q[$];

    dmem_resp_if bus_a();
    dmem_resp_if bus_b();

    assign bus_a.mreq  = tb_mreq & ~tb_sel;
    assign bus_a.write = tb_write;
    assign bus_a.size  = tb_size;
    assign bus_a.addr  = tb_addr;
    assign bus_a.wdata = tb_wdata;
    assign bus_b.mreq  = tb_mreq & tb_sel;
    assign bus_b.write = tb_write;
    assign bus_b.size  = tb_size;
    assign bus_b.addr  = tb_addr;
    assign bus_b.wdata = tb_wdata;

    wire        w_ack_n = tb_sel ? bus_b.ack_n : bus_a.ack_n;
    wire [31:0] w_rdata = tb_sel ? bus_b.rdata : bus_a.rdata;

    dmem_resp #(.LATENCY(3), .DEPTH_BYTES(DEPTH), .FIFO_DEPTH(4)) u_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a),
        .o_so_valid(so_valid_a), .o_so_data(so_data_a), .i_so_ready(1'b0),
        .o_exit(exit_a), .o_exit_code(exit_code_a), .o_err(err_a)
    );

    dmem_resp #(.LATENCY(1), .DEPTH_BYTES(DEPTH), .FIFO_DEPTH(4)) u_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b),
        .o_so_valid(so_valid_b), .o_so_data(so_data_b), .i_so_ready(so_ready_b),
        .o_exit(exit_b), .o_exit_code(exit_code_b), .o_err(err_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One access, entered and left at a falling edge; checks latency and load data.
    task automatic do_access(input bit s, input bit wr, input logic [1:0] sz,
                             input logic [31:0] ad, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input string nm);
        int  k;
        bit  got;
        logic [31:0] e;
        sb_q.push_back(exp_rd);
        tb_sel = s; tb_write = wr; tb_size = sz; tb_addr = ad; tb_wdata = wd;
        tb_mreq = 1'b1;
        k = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(posedge clk); @(negedge clk);
            k++;
            if (w_ack_n == 1'b0) got = 1'b1;
        end
        e = sb_q.pop_front();
        if (!got) begin
            chk({nm, "_ack_timeout"}, 32'(k), 32'(s ? 1 : 3));
        end else begin
            chk({nm, "_latency"}, 32'(k), 32'(s ? 1 : 3));
            chk({nm, "_rdata"}, w_rdata, e);
        end
        tb_mreq = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({nm, "_ack_release"}, {31'h0, w_ack_n}, 32'h1);
        chk({nm, "_rdata_clear"}, w_rdata, 32'h0);
    endtask

    typedef struct {
        bit          sel;
        bit          wr;
        logic [1:0]  sz;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    vec_t vt[14];

    initial begin
        int acked;
        int popped;
        logic [7:0] ch;
        logic [31:0] byte_exp[4];

        vt[0]  = '{1'b0, 1'b1, 2'b00, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 2'b01, BASE + 32'h12, 32'h0,         32'h0000_DEAD};
        vt[2]  = '{1'b0, 1'b0, 2'b00, BASE + 32'h10, 32'h0,         32'hDEAD_BEEF};
        vt[3]  = '{1'b0, 1'b0, 2'b01, BASE + 32'h10, 32'h0,         32'h0000_BEEF};
        vt[4]  = '{1'b0, 1'b0, 2'b10, BASE + 32'h11, 32'h0,         32'h0000_00BE};
        vt[5]  = '{1'b0, 1'b1, 2'b00, BASE + 32'h14, 32'hA5A5_A5A5, 32'h0};
        vt[6]  = '{1'b0, 1'b1, 2'b01, BASE + 32'h16, 32'h0000_1234, 32'h0};
        vt[7]  = '{1'b0, 1'b0, 2'b00, BASE + 32'h14, 32'h0,         32'h1234_A5A5};
        vt[8]  = '{1'b0, 1'b1, 2'b10, BASE + 32'h17, 32'h0000_0077, 32'h0};
        vt[9]  = '{1'b0, 1'b0, 2'b00, BASE + 32'h14, 32'h0,         32'h7734_A5A5};
        vt[10] = '{1'b0, 1'b1, 2'b00, BASE + 32'h20, 32'hCAFE_F00D, 32'h0};
        vt[11] = '{1'b0, 1'b0, 2'b00, SO_A,          32'h0,         32'h0};
        vt[12] = '{1'b0, 1'b0, 2'b00, EXIT_A,        32'h0,         32'h0};
        vt[13] = '{1'b1, 1'b1, 2'b00, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_ack_n_a", {31'h0, bus_a.ack_n}, 32'h1);
        chk("rst_ack_n_b", {31'h0, bus_b.ack_n}, 32'h1);
        chk("rst_rdata_a", bus_a.rdata, 32'h0);
        chk("rst_so_valid_b", {31'h0, so_valid_b}, 32'h0);
        chk("rst_so_data_b", {24'h0, so_data_b}, 32'h0);
        chk("rst_exit_a", {31'h0, exit_a}, 32'h0);
        chk("rst_exit_code_a", exit_code_a, 32'h0);
        chk("rst_err_a", {31'h0, err_a}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            do_access(vt[i].sel, vt[i].wr, vt[i].sz, vt[i].ad, vt[i].wd, vt[i].rd,
                      $sformatf("vec%0d", i));
        end
        chk("sink_loads_no_exit", {31'h0, exit_a}, 32'h0);
        chk("sink_loads_no_err", {31'h0, err_a}, 32'h0);

        // Back-to-back byte loads with mreq held on the single-cycle instance.
        byte_exp[0] = 32'hEF; byte_exp[1] = 32'hBE; byte_exp[2] = 32'hAD; byte_exp[3] = 32'hDE;
        tb_sel = 1'b1; tb_write = 1'b0; tb_size = 2'b10; tb_addr = BASE + 32'h10;
        tb_mreq = 1'b1;
        for (int i = 0; i < 4; i++) sb_q.push_back(byte_exp[i]);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("held_ack%0d", i), {31'h0, w_ack_n}, 32'h0);
            chk($sformatf("held_rdata%0d", i), w_rdata, sb_q.pop_front());
            tb_addr = BASE + 32'h11 + 32'(i);
        end
        tb_mreq = 1'b0;
        @(posedge clk); @(negedge clk);

        // Stdout FIFO fill, stall on full, then drain in order.
        so_ready_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ch = 8'h41 + 8'(i);
            so_q.push_back(ch);
            do_access(1'b1, 1'b1, 2'b10, SO_A, {24'h0, ch}, 32'h0, $sformatf("so_push%0d", i));
        end
        chk("so_valid_after_push", {31'h0, so_valid_b}, 32'h1);
        chk("so_head_A", {24'h0, so_data_b}, 32'h41);
        so_q.push_back(8'h45);
        tb_sel = 1'b1; tb_write = 1'b1; tb_size = 2'b10; tb_addr = SO_A; tb_wdata = 32'h45;
        tb_mreq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("so_stall%0d", i), {31'h0, w_ack_n}, 32'h1);
        end
        so_ready_b = 1'b1;
        acked = 0;
        popped = 0;
        for (int c = 0; c < 20 && popped < 5; c++) begin
            if (so_valid_b && so_ready_b) begin
                chk($sformatf("so_drain%0d", popped), {24'h0, so_data_b}, {24'h0, so_q.pop_front()});
                popped++;
            end
            @(posedge clk); @(negedge clk);
            if (w_ack_n == 1'b0) begin
                acked++;
                tb_mreq = 1'b0;
            end
        end
        chk("so_fifth_acks", 32'(acked), 32'h1);
        chk("so_drained", 32'(popped), 32'h5);
        chk("so_empty", {31'h0, so_valid_b}, 32'h0);
        so_ready_b = 1'b0;

        // Exit register is sticky and keeps the first code.
        do_access(1'b0, 1'b1, 2'b00, EXIT_A, 32'h0000_002A, 32'h0, "exit1");
        do_access(1'b0, 1'b1, 2'b10, EXIT_A, 32'h0000_0007, 32'h0, "exit2");
        chk("exit_set", {31'h0, exit_a}, 32'h1);
        chk("exit_code", exit_code_a, 32'h0000_002A);
        chk("exit_no_err", {31'h0, err_a}, 32'h0);
        do_access(1'b0, 1'b0, 2'b00, BASE + 32'h10, 32'h0, 32'hDEAD_BEEF, "post_exit_ld");

        // Word load straddling the end of storage.
        do_access(1'b0, 1'b0, 2'b00, BASE + 32'(DEPTH) - 32'h2, 32'h0, 32'h0, "oor_ld");
        chk("oor_err", {31'h0, err_a}, 32'h1);

        // Reset in the middle of a pending store must not commit it.
        tb_sel = 1'b0; tb_write = 1'b1; tb_size = 2'b00; tb_addr = BASE + 32'h20;
        tb_wdata = 32'h1122_3344; tb_mreq = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        tb_mreq = 1'b0;
        #1;
        chk("midrst_ack_n", {31'h0, bus_a.ack_n}, 32'h1);
        chk("midrst_err", {31'h0, err_a}, 32'h0);
        chk("midrst_exit", {31'h0, exit_a}, 32'h0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_access(1'b0, 1'b0, 2'b00, BASE + 32'h20, 32'h0, 32'hCAFE_F00D, "post_rst_ld");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
